uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Sits directly downstream of uart_rx and upstream of uart_tx.
- Parses the received byte stream into single-byte register read/write transactions on a simple internal register bus.
- Returns a one-byte response per command to uart_tx.
- Gives the host PC an interactive debug/control port over the 115200-baud link.

Parameters:
TIMEOUT_CYCLES, 1200000, idle clocks allowed between bytes of one command before the partial command is discarded (100 ms at 12 MHz)

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous reset, active-low
rx_data_i  input  8  received byte from uart_rx
rx_valid_i  input  1  one-cycle strobe, rx_data_i valid; no backpressure available
tx_data_o  output  8  response byte to uart_tx
tx_write_o  output  1  one-cycle strobe, tx_data_o valid; asserted only when tx_busy_i low
tx_busy_i  input  1  uart_tx busy
reg_addr_o  output  8  register bus address
reg_wdata_o  output  8  register bus write data
reg_write_o  output  1  one-cycle write strobe
reg_read_o  output  1  one-cycle read strobe
reg_rdata_i  input  8  read data, valid exactly one cycle after reg_read_o
busy_o  output  1  high whenever state != IDLE
overrun_o  output  1  sticky: a byte arrived while it could not be accepted

Behaviour:
- Reset (reset_n low at clock edge): state IDLE; all strobes 0; tx_data_o, reg_addr_o, reg_wdata_o = 0x00; timeout counter 0; overrun_o 0. Reset mid-command or mid-response aborts it; no strobe is issued.
- Command bytes:
  - 0x57 'W', addr, data -> register write; response 0x4B 'K'.
  - 0x52 'R', addr -> register read; response is the read byte.
  - 0x50 'P' -> ping; response 0x50.
  - Any other first byte -> response 0x3F '?'.
- States: IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ, CAPTURE, SEND.
- IDLE + rx_valid_i:
  - 'W' or 'R' -> GET_ADDR; opcode latched.
  - 'P' -> SEND with tx byte 0x50.
  - Any other byte -> SEND with tx byte 0x3F.
- GET_ADDR + rx_valid_i: latch reg_addr_o; opcode 'W' -> GET_DATA, 'R' -> DO_READ.
- GET_DATA + rx_valid_i: latch reg_wdata_o -> DO_WRITE.
- DO_WRITE: reg_write_o=1 for this single cycle; tx byte 0x4B -> SEND.
- DO_READ: reg_read_o=1 for this single cycle -> CAPTURE.
- CAPTURE: tx byte <= reg_rdata_i -> SEND.
- SEND: tx_write_o=1 in the first cycle with tx_busy_i=0, then IDLE in the same edge. Remains in SEND while tx_busy_i=1; no timeout in SEND.
- Latency, with the final byte's rx_valid_i in cycle N:
  - Write: reg_write_o at N+1; tx_write_o no earlier than N+2.
  - Read: reg_read_o at N+1; capture at N+2; tx_write_o no earlier than N+3.
  - Ping or unknown opcode: tx_write_o no earlier than N+1.
- tx_data_o holds its value from entry to SEND until the next response is loaded.
- Timeout:
  - Counter clears on every accepted byte and on entry to GET_ADDR.
  - Counter increments each cycle in GET_ADDR/GET_DATA.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid_i that cycle: -> IDLE, no strobe, no response.
  - rx_valid_i in the same cycle as expiry wins; the byte is accepted.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Overrun: rx_valid_i in DO_WRITE, DO_READ, CAPTURE or SEND drops the byte and sets overrun_o; cleared only by reset.
- reg_write_o and reg_read_o are never high in the same cycle.
- At most one tx_write_o per command.

Test Plan:
- Reset, then bytes 0x57,0x12,0xA5 -> exactly one reg_write_o pulse with reg_addr_o=0x12, reg_wdata_o=0xA5, one cycle after the third rx_valid_i; then tx_write_o with tx_data_o=0x4B.
- Bytes 0x52,0x34; bench returns reg_rdata_i=0xC3 the cycle after reg_read_o -> reg_addr_o=0x34, tx_data_o=0xC3, one tx_write_o; reg_write_o stays 0.
- tx_busy_i held high 500 cycles during a ping (0x50) -> no tx_write_o while busy; single tx_write_o, tx_data_o=0x50, the cycle tx_busy_i falls; busy_o low after.
- TIMEOUT_CYCLES=16: send 0x57, wait 20 idle cycles, then 0x50 -> no reg strobes; response 0x50 only. Repeat with a byte arriving at exactly count 15 -> byte accepted as the address.
- Send 0x41 (unknown) and, while tx_busy_i=1 in SEND, inject 0x52 -> response 0x3F; 0x52 dropped; overrun_o=1 and stays 1 until reset_n pulse.
- Assert reset_n=0 one cycle after 0x57,0x12 have been received, release, then send 0xA5 -> treated as an unknown opcode, response 0x3F; no reg_write_o ever.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// Byte stream, response and register bus signals of uart_cmd_decoder.
// The slave side is the decoder; the master side is its surroundings.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] tx_data_o;
  logic       tx_write_o;
  logic       tx_busy_i;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_write_o;
  logic       reg_read_o;
  logic [7:0] reg_rdata_i;
  logic       busy_o;
  logic       overrun_o;

  modport master (
    output rx_data_i, rx_valid_i,
    output tx_busy_i, reg_rdata_i,
    input  tx_data_o, tx_write_o,
    input  reg_addr_o, reg_wdata_o,
    input  reg_write_o, reg_read_o,
    input  busy_o, overrun_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i,
    input  tx_busy_i, reg_rdata_i,
    output tx_data_o, tx_write_o,
    output reg_addr_o, reg_wdata_o,
    output reg_write_o, reg_read_o,
    output busy_o, overrun_o
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART byte-stream parser: W/R/P commands to a register bus,
// one response byte per command back to the transmitter.
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input logic             clock,
  input logic             reset_n,
  uart_cmd_decoder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] OP_P  = 8'h50;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    DO_WRITE,
    DO_READ,
    CAPTURE,
    SEND
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_write;
  logic [7:0]    tx_data;
  logic [7:0]    addr;
  logic [7:0]    wdata;
  logic          wr;
  logic          rd;
  logic          ovr;
  logic          drop;
  logic          expired;

  // Bytes arriving while a command is being executed are lost.
  assign drop = bus.rx_valid_i &&
    (state inside {DO_WRITE, DO_READ, CAPTURE, SEND});
  assign expired = (cnt == LAST) && !bus.rx_valid_i;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
      tx_data  <= 8'h00;
      addr     <= 8'h00;
      wdata    <= 8'h00;
      wr       <= 1'b0;
      rd       <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      wr <= 1'b0;
      rd <= 1'b0;
      if (drop) ovr <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.rx_valid_i) begin
            cnt <= '0;
            unique case (1'b1)
              (bus.rx_data_i == OP_W),
              (bus.rx_data_i == OP_R): begin
                is_write <= (bus.rx_data_i == OP_W);
                state    <= GET_ADDR;
              end
              (bus.rx_data_i == OP_P): begin
                tx_data <= OP_P;
                state   <= SEND;
              end
              default: begin
                tx_data <= RSP_Q;
                state   <= SEND;
              end
            endcase
          end
        end
        GET_ADDR: begin
          if (bus.rx_valid_i) begin
            addr  <= bus.rx_data_i;
            cnt   <= '0;
            rd    <= !is_write;
            state <= is_write ? GET_DATA : DO_READ;
          end else if (expired) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GET_DATA: begin
          if (bus.rx_valid_i) begin
            wdata <= bus.rx_data_i;
            cnt   <= '0;
            wr    <= 1'b1;
            state <= DO_WRITE;
          end else if (expired) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DO_WRITE: begin
          tx_data <= RSP_K;
          state   <= SEND;
        end
        DO_READ: state <= CAPTURE;
        CAPTURE: begin
          tx_data <= bus.reg_rdata_i;
          state   <= SEND;
        end
        SEND: begin
          if (!bus.tx_busy_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by busy directly so a strobe can never meet a busy transmitter.
  assign bus.tx_write_o  = (state == SEND) && !bus.tx_busy_i;
  assign bus.tx_data_o   = tx_data;
  assign bus.reg_addr_o  = addr;
  assign bus.reg_wdata_o = wdata;
  assign bus.reg_write_o = wr;
  assign bus.reg_read_o  = rd;
  assign bus.busy_o      = (state != IDLE);
  assign bus.overrun_o   = ovr;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Random and directed command streams for uart_cmd_decoder,
// checked against a transaction-level register/response model.
module tb_uart_cmd_decoder;
  localparam int TO = 16;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } ev_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  uart_cmd_decoder_if bus();

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rx = 0;
  logic [7:0] regs [256];
  logic [7:0] model [256];
  logic pend_rd = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  logic busy_rand = 1'b0;
  logic busy_force = 1'b0;
  ev_t wr_q [$];
  ev_t rd_q [$];
  ev_t tx_q [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: record every bus/tx event with its cycle number.
  always @(negedge clock) begin
    pend_rd   <= bus.reg_read_o;
    pend_addr <= bus.reg_addr_o;
    if (bus.reg_write_o) begin
      wr_q.push_back('{a: bus.reg_addr_o,
                       d: bus.reg_wdata_o, c: cyc});
      regs[bus.reg_addr_o] <= bus.reg_wdata_o;
    end
    if (bus.reg_read_o)
      rd_q.push_back('{a: bus.reg_addr_o, d: 8'h00, c: cyc});
    if (bus.tx_write_o)
      tx_q.push_back('{a: 8'h00, d: bus.tx_data_o, c: cyc});
    if (bus.reg_write_o || bus.reg_read_o)
      check("strobe_excl",
            32'(bus.reg_write_o & bus.reg_read_o), 0);
    if (bus.tx_write_o)
      check("tx_while_busy", 32'(bus.tx_busy_i), 0);
  end

  // Register file and transmitter: read data appears the cycle
  // after the read strobe; busy is random or forced.
  initial begin
    bus.reg_rdata_i = 8'h00;
    bus.tx_busy_i   = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      bus.reg_rdata_i = pend_rd ? regs[pend_addr]
                                : 8'($urandom);
      bus.tx_busy_i = busy_rand ? ($urandom_range(0, 2) == 0)
                                : busy_force;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] b);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    last_rx = cyc;
    tick(1);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic clear_q();
    wr_q.delete();
    rd_q.delete();
    tx_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy_o && n < 600) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, 32'(bus.busy_o), 0);
  endtask

  function automatic int cmd_len(input logic [7:0] op);
    if (op == 8'h57) return 3;
    if (op == 8'h52) return 2;
    return 1;
  endfunction

  // Send op (+addr, +data) with given gaps; nb < full length
  // leaves the command to time out.
  task automatic trial(input logic [7:0] op,
                       input logic [7:0] a,
                       input logic [7:0] d,
                       input int nb, input int g1,
                       input int g2, input int tlat);
    int len;
    int lat;
    int lastc;
    logic [7:0] rsp;
    len = cmd_len(op);
    clear_q();
    put(op);
    if (nb > 1) begin
      tick(g1 - 1);
      put(a);
    end
    if (nb > 2) begin
      tick(g2 - 1);
      put(d);
    end
    lastc = last_rx;
    if (nb == len) begin
      lat = 1;
      rsp = 8'h3F;
      if (op == 8'h57) begin
        model[a] = d;
        rsp = 8'h4B;
        lat = 2;
      end else if (op == 8'h52) begin
        rsp = model[a];
        lat = 3;
      end else if (op == 8'h50) begin
        rsp = 8'h50;
      end
      wait_idle("trial");
      tick(2);
      check("wr_count", wr_q.size(), (op == 8'h57) ? 1 : 0);
      check("rd_count", rd_q.size(), (op == 8'h52) ? 1 : 0);
      check("tx_count", tx_q.size(), 1);
      if (op == 8'h57 && wr_q.size() == 1) begin
        check("wr_addr", wr_q[0].a, a);
        check("wr_data", wr_q[0].d, d);
        check("wr_cycle", wr_q[0].c, lastc + 1);
      end
      if (op == 8'h52 && rd_q.size() == 1) begin
        check("rd_addr", rd_q[0].a, a);
        check("rd_cycle", rd_q[0].c, lastc + 1);
      end
      if (tx_q.size() == 1) begin
        check("tx_data", tx_q[0].d, rsp);
        check("tx_latency",
              32'(tx_q[0].c - lastc >= lat), 1);
        if (tlat > 0)
          check("tx_cycle", tx_q[0].c, lastc + tlat);
      end
    end else begin
      tick(TO + 2);
      check("to_busy", 32'(bus.busy_o), 0);
      check("to_events",
            wr_q.size() + rd_q.size() + tx_q.size(), 0);
    end
    check("no_overrun", 32'(bus.overrun_o), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_tx_data"}, bus.tx_data_o, 0);
    check({tag, "_addr"}, bus.reg_addr_o, 0);
    check({tag, "_wdata"}, bus.reg_wdata_o, 0);
    check({tag, "_strobes"},
          {bus.reg_write_o, bus.reg_read_o, bus.tx_write_o}, 0);
    check({tag, "_busy"}, 32'(bus.busy_o), 0);
    check({tag, "_overrun"}, 32'(bus.overrun_o), 0);
  endtask

  initial begin
    int rel;
    int r;
    int len;
    int nb;
    logic [7:0] op;
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      regs[i]  = 8'($urandom);
      model[i] = regs[i];
    end
    tick(3);
    check_reset_outs("reset");
    reset_n = 1'b1;
    tick(1);

    trial(8'h57, 8'h12, 8'hA5, 3, 1, 1, 2);

    regs[8'h34]  = 8'hC3;
    model[8'h34] = 8'hC3;
    trial(8'h52, 8'h34, 8'h00, 2, 1, 1, 3);

    busy_force = 1'b1;
    clear_q();
    put(8'h50);
    tick(500);
    check("ping_busy_tx", tx_q.size(), 0);
    check("ping_busy_hold", 32'(bus.busy_o), 1);
    busy_force = 1'b0;
    rel = cyc;
    tick(1);
    check("ping_tx_count", tx_q.size(), 1);
    if (tx_q.size() == 1) begin
      check("ping_tx_data", tx_q[0].d, 8'h50);
      check("ping_tx_cycle", tx_q[0].c, rel);
    end
    tick(1);
    check("ping_done", 32'(bus.busy_o), 0);

    clear_q();
    put(8'h57);
    tick(20);
    put(8'h50);
    wait_idle("to20");
    tick(2);
    check("to20_reg", wr_q.size() + rd_q.size(), 0);
    check("to20_tx_count", tx_q.size(), 1);
    if (tx_q.size() == 1)
      check("to20_tx_data", tx_q[0].d, 8'h50);

    clear_q();
    put(8'h57);
    tick(TO);
    put(8'h50);
    wait_idle("to17");
    tick(2);
    check("to17_reg", wr_q.size() + rd_q.size(), 0);
    check("to17_tx_count", tx_q.size(), 1);

    trial(8'h57, 8'h07, 8'h5A, 3, TO, 1, 2);
    trial(8'h57, 8'h08, 8'h3C, 3, 1, TO, 2);
    trial(8'h52, 8'h07, 8'h00, 2, TO, 1, 3);

    busy_rand = 1'b1;
    repeat (200) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = 8'h57;
      else if (r < 7) op = 8'h52;
      else if (r == 7) op = 8'h50;
      else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52 || op == 8'h50)
          op = 8'($urandom);
      end
      len = cmd_len(op);
      nb = len;
      if (len > 1 && $urandom_range(0, 4) == 0)
        nb = $urandom_range(1, len - 1);
      trial(op, 8'($urandom_range(0, 15)), 8'($urandom), nb,
            ($urandom_range(0, 3) == 0) ? TO
                                        : $urandom_range(1, TO),
            ($urandom_range(0, 3) == 0) ? TO
                                        : $urandom_range(1, TO),
            0);
    end
    busy_rand = 1'b0;
    tick(2);

    busy_force = 1'b1;
    clear_q();
    put(8'h41);
    tick(3);
    put(8'h52);
    tick(3);
    check("ovr_set", 32'(bus.overrun_o), 1);
    busy_force = 1'b0;
    wait_idle("ovr");
    tick(3);
    check("ovr_tx_count", tx_q.size(), 1);
    if (tx_q.size() == 1)
      check("ovr_tx_data", tx_q[0].d, 8'h3F);
    check("ovr_dropped", wr_q.size() + rd_q.size(), 0);
    put(8'h50);
    wait_idle("ovr_ping");
    tick(2);
    check("ovr_sticky", 32'(bus.overrun_o), 1);

    clear_q();
    put(8'h57);
    put(8'h12);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_reset_outs("midrst");
    put(8'hA5);
    wait_idle("midrst");
    tick(2);
    check("midrst_no_wr", wr_q.size(), 0);
    check("midrst_tx_count", tx_q.size(), 1);
    if (tx_q.size() == 1)
      check("midrst_tx_data", tx_q[0].d, 8'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
